alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_if.sv | 30 +++
 rtl/alu_mc.sv | 140 ++++++++++++++
 tb/tb_alu_mc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle for the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] InA;
  logic [WIDTH-1:0] InB;
  logic             Cin;
  logic [3:0]       Oper;
  logic             invA;
  logic             invB;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             Zero;
  logic             Ofl;
  logic             busy;

  modport master (
    output in_valid, InA, InB, Cin, Oper, invA, invB, sign, out_ready,
    input  in_ready, out_valid, Out, Zero, Ofl, busy
  );

  modport slave (
    input  in_valid, InA, InB, Cin, Oper, invA, invB, sign, out_ready,
    output in_ready, out_valid, Out, Zero, Ofl, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle shift/add/logic ops plus a shift-add multiplier,
// with a valid/ready request side and a held result register on the output side.
module alu_mc #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);
  if (WIDTH != 2**SHAMT_W) begin : g_bad_param
    $error("alu_mc: WIDTH must equal 2**SHAMT_W");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [3:0] OP_ROL = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRA = 4'b0010;
  localparam logic [3:0] OP_SRL = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(WIDTH-1);
  localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     act_a, act_b;
  logic [SHAMT_W-1:0]   sh;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     rol, alu_res;
  logic                 alu_ofl;
  logic                 accept, is_mul;

  logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [SHAMT_W:0]     cnt;
  logic                 mul_last;

  logic [WIDTH-1:0]     out_q;
  logic                 zero_q, ofl_q;

  assign act_a  = bus.invA ? ~bus.InA : bus.InA;
  assign act_b  = bus.invB ? ~bus.InB : bus.InB;
  assign sh     = act_b[SHAMT_W-1:0];
  assign is_mul = (bus.Oper == OP_MUL);
  assign sum    = {1'b0, act_a} + {1'b0, act_b} + {{WIDTH{1'b0}}, bus.Cin};

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == MUL);
  assign bus.Out       = out_q;
  assign bus.Zero      = zero_q;
  assign bus.Ofl       = ofl_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    rol = '0;
    for (int i = 0; i < WIDTH; i++)
      rol[i] = act_a[(i + WIDTH - int'(sh)) % WIDTH];
  end

  // Reserved codes fall through to zero result with no overflow.
  always_comb begin
    alu_res = '0;
    alu_ofl = 1'b0;
    case (bus.Oper)
      OP_ROL: alu_res = rol;
      OP_SLL: alu_res = act_a << sh;
      OP_SRA: alu_res = $unsigned($signed(act_a) >>> sh);
      OP_SRL: alu_res = act_a >> sh;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_ofl = bus.sign ? ((act_a[WIDTH-1] == act_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != act_a[WIDTH-1]))
                           : sum[WIDTH];
      end
      OP_AND: alu_res = act_a & act_b;
      OP_OR:  alu_res = act_a | act_b;
      OP_XOR: alu_res = act_a ^ act_b;
      default: ;
    endcase
  end

  // One multiplier bit per MUL cycle; the WIDTH-th cycle writes the result.
  assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
  assign mul_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mul ? MUL : DONE;
      MUL:  if (mul_last) state_nxt = DONE;
      DONE: begin
        if (accept)             state_nxt = is_mul ? MUL : DONE;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out_q  <= '0;
      zero_q <= 1'b0;
      ofl_q  <= 1'b0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, act_a};
      mplier <= act_b;
      acc    <= '0;
      cnt    <= '0;
      if (!is_mul) begin
        out_q  <= alu_res;
        zero_q <= (alu_res == '0);
        ofl_q  <= alu_ofl;
      end
    end else if (state == MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
      cnt    <= cnt + CNT_ONE;
      if (mul_last) begin
        out_q  <= acc_nxt[WIDTH-1:0];
        zero_q <= (acc_nxt[WIDTH-1:0] == '0);
        ofl_q  <= |acc_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed vectors checked with immediate assertions.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   bc, cyc, nv;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(16)) bus();

  alu_mc #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic ia, input logic ib, input logic sg);
    bus.Oper = op; bus.InA = a; bus.InB = b; bus.Cin = cin;
    bus.invA = ia; bus.invB = ib; bus.sign = sg;
  endtask

  // Presents a request for exactly one edge; returns #1 after that edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic ia, input logic ib, input logic sg);
    @(negedge clk);
    set_req(op, a, b, cin, ia, ib, sg);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic res(input string tag, input logic [15:0] o, input logic z, input logic f);
    chkb({tag, "_vld"}, bus.out_valid, 1'b1);
    chk16({tag, "_out"}, bus.Out, o);
    chkb({tag, "_zero"}, bus.Zero, z);
    chkb({tag, "_ofl"}, bus.Ofl, f);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_req(4'b0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    #12;
    chkb("rst_in_ready", bus.in_ready, 1'b1);
    chkb("rst_out_valid", bus.out_valid, 1'b0);
    chkb("rst_busy", bus.busy, 1'b0);
    chk16("rst_out", bus.Out, 16'h0000);
    chkb("rst_zero", bus.Zero, 1'b0);
    chkb("rst_ofl", bus.Ofl, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    send(4'b0100, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1); res("add_sovf", 16'h8000, 1'b0, 1'b1);
    send(4'b0100, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1); res("add_sub0", 16'h0000, 1'b1, 1'b0);
    send(4'b0000, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0); res("rol4", 16'h0018, 1'b0, 1'b0);
    send(4'b0010, 16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0); res("sra15", 16'hFFFF, 1'b0, 1'b0);
    send(4'b0011, 16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0); res("srl15", 16'h0001, 1'b0, 1'b0);
    send(4'b0001, 16'h1234, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0); res("sll0", 16'h1234, 1'b0, 1'b0);
    send(4'b0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); res("rol0", 16'h1234, 1'b0, 1'b0);
    send(4'b0010, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); res("sra0", 16'h8000, 1'b0, 1'b0);
    send(4'b0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0); res("sll3", 16'h0008, 1'b0, 1'b0);
    send(4'b0101, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 1'b0, 1'b0); res("and", 16'h3030, 1'b0, 1'b0);
    send(4'b0110, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 1'b0, 1'b0); res("or", 16'hFCFC, 1'b0, 1'b0);
    send(4'b0111, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 1'b0, 1'b0); res("xor", 16'hCCCC, 1'b0, 1'b0);
    send(4'b0101, 16'h00FF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0); res("and_inva", 16'hFF00, 1'b0, 1'b0);
    send(4'b0100, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0); res("add_cout", 16'h0000, 1'b1, 1'b1);
    send(4'b0100, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0); res("add_nores", 16'h0002, 1'b0, 1'b0);
    send(4'b1111, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0); res("reserved", 16'h0000, 1'b1, 1'b0);

    // 0x100 * 0x100: product lands entirely in the high half
    send(4'b1000, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    bc = 0; cyc = 0;
    while (!bus.out_valid && cyc < 60) begin
      if (bus.busy) bc++;
      @(posedge clk); #1; cyc++;
    end
    chki("mul_busy_cycles", bc, 16);
    chki("mul_latency", cyc, 16);
    res("mul_big", 16'h0000, 1'b1, 1'b1);

    // a request raised during MUL must be ignored
    send(4'b1000, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    set_req(4'b0100, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    chkb("mul_in_ready", bus.in_ready, 1'b0);
    bc = 0; cyc = 0;
    while (!bus.out_valid && cyc < 60) begin
      if (bus.busy) bc++;
      if (cyc == 3) bus.in_valid = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    chki("mul2_latency", cyc, 16);
    res("mul_small", 16'h000F, 1'b0, 1'b0);

    // consumer stalls with a pending request
    send(4'b0100, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    set_req(4'b0111, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    res("stall_first", 16'h0003, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk16("stall_out", bus.Out, 16'h0003);
      chkb("stall_vld", bus.out_valid, 1'b1);
      chkb("stall_in_ready", bus.in_ready, 1'b0);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    res("stall_next", 16'hFFFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    chkb("idle_vld", bus.out_valid, 1'b0);
    chkb("idle_in_ready", bus.in_ready, 1'b1);

    // reset pulse in MUL cycle 5
    send(4'b1000, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chkb("mrst_out_valid", bus.out_valid, 1'b0);
    chkb("mrst_busy", bus.busy, 1'b0);
    chk16("mrst_out", bus.Out, 16'h0000);
    chkb("mrst_zero", bus.Zero, 1'b0);
    chkb("mrst_ofl", bus.Ofl, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    #1 chkb("mrst_in_ready", bus.in_ready, 1'b1);
    nv = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) nv++;
    end
    chki("mrst_no_valid", nv, 0);

    send(4'b0100, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0); res("post_rst_add", 16'h0005, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
